// File: rtl/sifh_hist_engine.sv
// Per-pixel timestamp histogram engine: a coarse pass finds each pixel's peak bin, then an
// optional fine pass re-bins a 2^NB-wide window around that peak at full timestamp resolution.
module sifh_hist_engine #(
    parameter int NP      = 12,
    parameter int NB      = 6,
    parameter int PIXELS  = 4,
    parameter int SAMPLES = 2,
    parameter int ACQ     = 16,
    parameter int CW      = 8,
    parameter int FINE_EN = 1,
    localparam int PW     = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
    input  logic          clk,
    input  logic          res,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NP-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_pixel,
    output logic [NP-1:0] out_peak,
    output logic [CW-1:0] out_count,
    output logic          busy,
    output logic          pass
);

    localparam int NBINS = 1 << NB;
    localparam int DEPTH = PIXELS * NBINS;
    localparam int AW    = PW + NB;
    localparam int SW    = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int QW    = (ACQ > 1) ? $clog2(ACQ) : 1;
    localparam int SH    = NP - NB;
    localparam int LW    = NP + 2;
    localparam logic signed [LW-1:0] LO_OFS = LW'((1 << (SH - 1)) - (1 << (NB - 1)));
    localparam logic signed [LW-1:0] LO_MAX = LW'((1 << NP) - (1 << NB));

    typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_WINDOW, S_OUTPUT} state_t;

    state_t        r_state;
    logic [AW-1:0] r_clr_addr;
    logic          r_pass;
    logic          r_in_ready;
    logic          r_done;
    logic [SW-1:0] r_samp;
    logic [PW-1:0] r_pix;
    logic [QW-1:0] r_acq;
    logic [NP-1:0] r_lo       [PIXELS];
    logic [CW-1:0] r_max      [PIXELS];
    logic [NB-1:0] r_peak_bin [PIXELS];

    logic          r_s1_valid;
    logic [PW-1:0] r_s1_pix;
    logic [NB-1:0] r_s1_bin;
    logic          r_s2_valid;
    logic [AW-1:0] r_s2_addr;
    logic [CW-1:0] r_s2_count;

    logic [CW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_rd_data;

    logic          r_out_valid;
    logic [PW-1:0] r_out_pixel;
    logic [NP-1:0] r_out_peak;
    logic [CW-1:0] r_out_count;

    logic          w_accept;
    logic          w_last;
    logic          w_nophoton;
    logic          w_in_win;
    logic [NP:0]   w_diff;
    logic [NP-1:0] w_lo_cur;
    logic [NB-1:0] w_bin;
    logic          w_hit;
    logic [AW-1:0] w_raddr;
    logic [AW-1:0] w_s1_addr;
    logic [CW-1:0] w_base;
    logic [CW-1:0] w_new_count;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [CW-1:0] w_wdata;
    logic [PW-1:0] w_out_next;
    logic [NP-1:0] w_lo_calc  [PIXELS];
    logic [NP-1:0] w_res_peak [PIXELS];

    assign w_accept   = in_valid & r_in_ready;
    assign w_last     = (r_samp == SW'(SAMPLES - 1)) && (r_pix == PW'(PIXELS - 1)) &&
                        (r_acq == QW'(ACQ - 1));
    assign w_nophoton = &in_data;
    assign w_lo_cur   = r_lo[r_pix];
    assign w_diff     = {1'b0, in_data} - {1'b0, w_lo_cur};
    assign w_in_win   = (w_diff[NP:NB] == '0);
    assign w_bin      = r_pass ? w_diff[NB-1:0] : in_data[NP-1:SH];
    assign w_hit      = !w_nophoton && (!r_pass || w_in_win);
    assign w_raddr    = {r_pix, w_bin};
    assign w_s1_addr  = {r_s1_pix, r_s1_bin};

    // The read for the current stage-1 sample was issued on the same edge as the previous
    // write, so a matching address must take the just-written count instead of the stale read.
    assign w_base      = (r_s2_valid && (r_s2_addr == w_s1_addr)) ? r_s2_count : r_rd_data;
    assign w_new_count = (&w_base) ? w_base : w_base + 1'b1;
    assign w_out_next  = r_out_pixel + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < PIXELS; gi++) begin : g_pix
            logic signed [LW-1:0] w_lo_raw;
            assign w_lo_raw       = $signed({2'b00, r_peak_bin[gi], {SH{1'b0}}}) + LO_OFS;
            assign w_lo_calc[gi]  = w_lo_raw[LW-1]      ? '0 :
                                    (w_lo_raw > LO_MAX) ? LO_MAX[NP-1:0] : w_lo_raw[NP-1:0];
            assign w_res_peak[gi] = r_pass ? (r_lo[gi] + {{SH{1'b0}}, r_peak_bin[gi]})
                                           : {r_peak_bin[gi], {SH{1'b0}}};
        end
    endgenerate

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_addr;
        w_wdata = '0;
        if (!res) begin
            if (r_state == S_CLEAR) begin
                w_we = 1'b1;
            end else if (r_s1_valid) begin
                w_we    = 1'b1;
                w_waddr = w_s1_addr;
                w_wdata = w_new_count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rd_data <= r_mem[w_raddr];
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state     <= S_CLEAR;
            r_clr_addr  <= '0;
            r_pass      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_done      <= 1'b0;
            r_samp      <= '0;
            r_pix       <= '0;
            r_acq       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_pix    <= '0;
            r_s1_bin    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_addr   <= '0;
            r_s2_count  <= '0;
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_peak  <= '0;
            r_out_count <= '0;
            for (int p = 0; p < PIXELS; p++) begin
                r_lo[p]       <= '0;
                r_max[p]      <= '0;
                r_peak_bin[p] <= '0;
            end
        end else begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= r_s1_valid;
            r_s2_addr  <= w_s1_addr;
            r_s2_count <= w_new_count;
            if (r_s1_valid && (w_new_count > r_max[r_s1_pix])) begin
                r_max[r_s1_pix]      <= w_new_count;
                r_peak_bin[r_s1_pix] <= r_s1_bin;
            end

            case (r_state)
                S_CLEAR: begin
                    for (int p = 0; p < PIXELS; p++) begin
                        r_max[p]      <= '0;
                        r_peak_bin[p] <= '0;
                    end
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == AW'(DEPTH - 1)) begin
                        r_clr_addr <= '0;
                        r_state    <= S_ACCUM;
                        r_in_ready <= 1'b1;
                        r_samp     <= '0;
                        r_pix      <= '0;
                        r_acq      <= '0;
                        r_done     <= 1'b0;
                    end
                end

                S_ACCUM: begin
                    if (w_accept) begin
                        r_s1_valid <= w_hit;
                        r_s1_pix   <= r_pix;
                        r_s1_bin   <= w_bin;
                        if (r_samp == SW'(SAMPLES - 1)) begin
                            r_samp <= '0;
                            if (r_pix == PW'(PIXELS - 1)) begin
                                r_pix <= '0;
                                r_acq <= (r_acq == QW'(ACQ - 1)) ? '0 : r_acq + 1'b1;
                            end else begin
                                r_pix <= r_pix + 1'b1;
                            end
                        end else begin
                            r_samp <= r_samp + 1'b1;
                        end
                        if (w_last) begin
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end else if (r_done && !r_s1_valid) begin
                        // Last update has committed to the max/peak registers by now.
                        r_done <= 1'b0;
                        if ((FINE_EN != 0) && !r_pass) begin
                            r_state <= S_WINDOW;
                        end else begin
                            r_state     <= S_OUTPUT;
                            r_out_valid <= 1'b1;
                            r_out_pixel <= '0;
                            r_out_peak  <= w_res_peak[0];
                            r_out_count <= r_max[0];
                        end
                    end
                end

                S_WINDOW: begin
                    for (int p = 0; p < PIXELS; p++) begin
                        r_lo[p] <= w_lo_calc[p];
                    end
                    r_pass     <= 1'b1;
                    r_clr_addr <= '0;
                    r_state    <= S_CLEAR;
                end

                S_OUTPUT: begin
                    if (out_ready) begin
                        if (r_out_pixel == PW'(PIXELS - 1)) begin
                            r_out_valid <= 1'b0;
                            r_out_pixel <= '0;
                            r_out_peak  <= '0;
                            r_out_count <= '0;
                            r_pass      <= 1'b0;
                            r_clr_addr  <= '0;
                            r_state     <= S_CLEAR;
                            for (int p = 0; p < PIXELS; p++) begin
                                r_lo[p] <= '0;
                            end
                        end else begin
                            r_out_pixel <= w_out_next;
                            r_out_peak  <= w_res_peak[w_out_next];
                            r_out_count <= r_max[w_out_next];
                        end
                    end
                end

                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign out_peak  = r_out_peak;
    assign out_count = r_out_count;
    assign busy      = (r_state != S_ACCUM);
    assign pass      = r_pass;

endmodule

// File: tb/tb_sifh_hist_engine.sv
// Randomized frames against a sequential histogram model; a second coarse-only instance
// covers count saturation.
module tb_sifh_hist_engine;

    localparam int NP    = 12;
    localparam int NB    = 6;
    localparam int PIX   = 4;
    localparam int SMP   = 2;
    localparam int ACQ   = 16;
    localparam int CW    = 8;
    localparam int NS    = ACQ * PIX * SMP;
    localparam int B_ACQ = 300;
    localparam int B_NS  = B_ACQ * PIX * SMP;
    localparam int SHV   = NP - NB;
    localparam int NBIN  = 1 << NB;
    localparam int SAT   = (1 << CW) - 1;
    localparam int NOPH  = (1 << NP) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          res, in_valid, in_ready, out_valid, out_ready, busy, pass;
    logic [NP-1:0] in_data, out_peak;
    logic [1:0]    out_pixel;
    logic [CW-1:0] out_count;

    logic          b_res, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_pass;
    logic [NP-1:0] b_in_data, b_out_peak;
    logic [1:0]    b_out_pixel;
    logic [CW-1:0] b_out_count;

    sifh_hist_engine #(.NP(NP), .NB(NB), .PIXELS(PIX), .SAMPLES(SMP), .ACQ(ACQ), .CW(CW),
                       .FINE_EN(1)) u_dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_peak(out_peak), .out_count(out_count), .busy(busy), .pass(pass)
    );

    sifh_hist_engine #(.NP(NP), .NB(NB), .PIXELS(PIX), .SAMPLES(SMP), .ACQ(B_ACQ), .CW(CW),
                       .FINE_EN(0)) u_dut_b (
        .clk(clk), .res(b_res), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pixel(b_out_pixel), .out_peak(b_out_peak), .out_count(b_out_count),
        .busy(b_busy), .pass(b_pass)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    int cs [NS];
    int fs [NS];
    int exp_peak [PIX];
    int exp_cnt  [PIX];
    int ctr      [PIX];

    // Histogram both passes in arrival order; a bin becomes the peak only by exceeding the max.
    task automatic model_frame();
        int hist [PIX][NBIN];
        int mx [PIX];
        int pk [PIX];
        int lo [PIX];
        int p, b, d;
        for (int q = 0; q < PIX; q++) begin
            mx[q] = 0; pk[q] = 0;
            for (int k = 0; k < NBIN; k++) hist[q][k] = 0;
        end
        for (int i = 0; i < NS; i++) begin
            p = (i / SMP) % PIX;
            d = cs[i];
            if (d != NOPH) begin
                b = d >> SHV;
                if (hist[p][b] < SAT) hist[p][b]++;
                if (hist[p][b] > mx[p]) begin mx[p] = hist[p][b]; pk[p] = b; end
            end
        end
        for (int q = 0; q < PIX; q++) begin
            lo[q] = (pk[q] << SHV) + (1 << (SHV - 1)) - (1 << (NB - 1));
            if (lo[q] < 0) lo[q] = 0;
            if (lo[q] > (1 << NP) - NBIN) lo[q] = (1 << NP) - NBIN;
            mx[q] = 0; pk[q] = 0;
            for (int k = 0; k < NBIN; k++) hist[q][k] = 0;
        end
        for (int i = 0; i < NS; i++) begin
            p = (i / SMP) % PIX;
            d = fs[i];
            if (d != NOPH && d >= lo[p] && d <= lo[p] + NBIN - 1) begin
                b = d - lo[p];
                if (hist[p][b] < SAT) hist[p][b]++;
                if (hist[p][b] > mx[p]) begin mx[p] = hist[p][b]; pk[p] = b; end
            end
        end
        for (int q = 0; q < PIX; q++) begin
            exp_peak[q] = lo[q] + pk[q];
            exp_cnt[q]  = mx[q];
        end
    endtask

    function automatic int gen(input int c);
        int r, v;
        r = int'($urandom_range(0, 7));
        if (r == 0) return NOPH;
        if (r == 1) return int'($urandom_range(0, NOPH - 1));
        v = c + int'($urandom_range(0, 40)) - 20;
        if (v < 0) v = 0;
        if (v > NOPH - 1) v = NOPH - 1;
        return v;
    endfunction

    task automatic measure_clear();
        int c = 0;
        while (!in_ready && c < 2000) begin c++; @(negedge clk); end
        check("ready_low_cycles", c, 256);
    endtask

    task automatic send_pass(input int which, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) begin in_valid = 1'b0; @(negedge clk); end
            in_valid = 1'b1;
            in_data  = (which == 0) ? NP'(cs[i]) : NP'(fs[i]);
            t = 0;
            while (!in_ready && t < 5000) begin @(negedge clk); t++; end
            if (!in_ready) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            if (i == 0) begin
                check("pass_in_accum", int'(pass), which);
                check("busy_in_accum", int'(busy), 0);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int stall_pix, input int stall_len);
        int t, k, ok;
        for (int p = 0; p < PIX; p++) begin
            t = 0;
            while (!out_valid && t < 5000) begin @(negedge clk); t++; end
            if (!out_valid) begin check("out_valid_timeout", 0, 1); return; end
            $display("[TB] out pixel=%0d peak=0x%0h count=%0d (exp 0x%0h %0d)",
                     out_pixel, out_peak, out_count, exp_peak[p], exp_cnt[p]);
            check("out_pixel", int'(out_pixel), p);
            check("out_peak", int'(out_peak), exp_peak[p]);
            check("out_count", int'(out_count), exp_cnt[p]);
            check("in_ready_in_output", int'(in_ready), 0);
            k = (p == stall_pix) ? stall_len : int'($urandom_range(0, 2));
            for (int j = 0; j < k; j++) begin
                @(negedge clk);
                if (p == stall_pix) begin
                    ok = (out_valid && int'(out_pixel) == p && int'(out_peak) == exp_peak[p] &&
                          int'(out_count) == exp_cnt[p] && !in_ready) ? 1 : 0;
                    check("stall_stable", ok, 1);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check("out_valid_after_frame", int'(out_valid), 0);
        check("pass_after_frame", int'(pass), 0);
        check("busy_after_frame", int'(busy), 1);
    endtask

    task automatic run_frame(input int stall_pix, input int stall_len);
        model_frame();
        send_pass(0, NS);
        send_pass(1, NS);
        collect(stall_pix, stall_len);
    endtask

    task automatic random_frame(input int stall_pix);
        for (int p = 0; p < PIX; p++) ctr[p] = int'($urandom_range(0, NOPH - 1));
        for (int i = 0; i < NS; i++) begin
            cs[i] = gen(ctr[(i / SMP) % PIX]);
            fs[i] = gen(ctr[(i / SMP) % PIX]);
        end
        run_frame(stall_pix, 10);
    endtask

    initial begin
        int t, seen_pass1;
        int b_exp_peak [PIX];
        int b_exp_cnt  [PIX];
        res = 1'b1; b_res = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_out_peak", int'(out_peak), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_pass", int'(pass), 0);
        res = 1'b0; b_res = 1'b0;
        measure_clear();

        // Every sample at 0x2A5: coarse bin 10, window at 640, 32 hits per pixel.
        for (int i = 0; i < NS; i++) begin cs[i] = 'h2A5; fs[i] = 'h2A5; end
        run_frame(-1, 0);

        // Only pixel 2 sees photons; top window with a no-photon code inside its range.
        for (int i = 0; i < NS; i++) begin
            cs[i] = (((i / SMP) % PIX) == 2) ? 'hFC0 : NOPH;
            fs[i] = (((i / SMP) % PIX) == 2) ? 'hFFE : NOPH;
        end
        run_frame(-1, 0);

        random_frame(int'($urandom_range(0, PIX - 1)));
        random_frame(-1);
        random_frame(-1);

        // Reset in the middle of the fine pass, with a sample still in flight.
        for (int p = 0; p < PIX; p++) ctr[p] = int'($urandom_range(0, NOPH - 1));
        for (int i = 0; i < NS; i++) begin
            cs[i] = gen(ctr[(i / SMP) % PIX]);
            fs[i] = gen(ctr[(i / SMP) % PIX]);
        end
        send_pass(0, NS);
        send_pass(1, 20);
        res = 1'b1;
        @(negedge clk);
        check("midrst_pass", int'(pass), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_busy", int'(busy), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        res = 1'b0;
        measure_clear();
        for (int i = 0; i < NS; i++) begin cs[i] = 'h2A5; fs[i] = 'h2A5; end
        run_frame(-1, 0);

        // Coarse-only instance: pixel 0 saturates, others never see a photon.
        seen_pass1 = 0;
        for (int i = 0; i < B_NS; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = (((i / SMP) % PIX) == 0) ? NP'('h100) : NP'(NOPH);
            t = 0;
            while (!b_in_ready && t < 5000) begin @(negedge clk); t++; end
            if (!b_in_ready) begin check("b_in_ready_timeout", 0, 1); break; end
            @(negedge clk);
            if (b_pass) seen_pass1 = 1;
        end
        b_in_valid = 1'b0;
        b_exp_peak[0] = 'h100; b_exp_cnt[0] = SAT;
        for (int p = 1; p < PIX; p++) begin b_exp_peak[p] = 0; b_exp_cnt[p] = 0; end
        for (int p = 0; p < PIX; p++) begin
            t = 0;
            while (!b_out_valid && t < 5000) begin
                if (b_pass) seen_pass1 = 1;
                @(negedge clk); t++;
            end
            if (!b_out_valid) begin check("b_out_valid_timeout", 0, 1); break; end
            $display("[TB] coarse-only out pixel=%0d peak=0x%0h count=%0d",
                     b_out_pixel, b_out_peak, b_out_count);
            check("b_out_pixel", int'(b_out_pixel), p);
            check("b_out_peak", int'(b_out_peak), b_exp_peak[p]);
            check("b_out_count", int'(b_out_count), b_exp_cnt[p]);
            check("b_busy_output", int'(b_busy), 1);
            if (b_pass) seen_pass1 = 1;
            b_out_ready = 1'b1;
            @(negedge clk);
            b_out_ready = 1'b0;
        end
        check("b_single_pass", seen_pass1, 0);
        check("b_out_valid_after", int'(b_out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sifh_hist_engine.md
SIFH_HIST_ENGINE -- requirements
Module: sifh_hist_engine

Interface
REQ-001 SHALL provide parameter NP, default 12, timestamp width in bits.
REQ-002 SHALL provide parameter NB, default 6, histogram bin-address width; 2^NB bins per pixel; NB < NP.
REQ-003 SHALL provide parameter PIXELS, default 4, pixels sharing one histogram memory.
REQ-004 SHALL provide parameter SAMPLES, default 2, consecutive samples per pixel per acquisition.
REQ-005 SHALL provide parameter ACQ, default 16, acquisitions per pass.
REQ-006 SHALL provide parameter CW, default 8, bin-count width, saturating.
REQ-007 SHALL provide parameter FINE_EN, default 1; 1 = coarse+fine passes, 0 = coarse only.
REQ-008 SHALL provide port clk, input, 1, sole clock; all logic on its rising edge.
REQ-009 SHALL provide port res, input, 1, synchronous active-high reset.
REQ-010 SHALL provide ports in_valid input 1, in_ready output 1, in_data input NP: sample stream, transfer when both valid and ready high.
REQ-011 SHALL provide ports out_valid output 1, out_ready input 1: result handshake.
REQ-012 SHALL provide ports out_pixel output clog2(PIXELS), out_peak output NP, out_count output CW: per-pixel result.
REQ-013 SHALL provide ports busy output 1 (high outside ACCUM) and pass output 1 (0 coarse, 1 fine).

Function
REQ-014 SHALL implement states CLEAR, ACCUM, WINDOW, OUTPUT.
REQ-015 CLEAR SHALL zero one bin per cycle, PIXELS*2^NB cycles, plus per-pixel max/peak registers, then enter ACCUM; in_ready=0.
REQ-016 ACCUM SHALL hold in_ready=1; accepted samples belong to pixel 0 for SAMPLES transfers, then pixel 1, ..., pixel PIXELS-1, repeated ACQ times.
REQ-017 All-ones in_data SHALL be "no photon": consumed, counted toward the sequence, not binned.
REQ-018 Coarse pass bin SHALL be in_data[NP-1:NP-NB].
REQ-019 Fine pass: lo_p = clamp(C_p + 2^(NP-NB-1) - 2^(NB-1), 0, 2^NP-2^NB), C_p = coarse peak bin << (NP-NB); sample in [lo_p, lo_p+2^NB-1] SHALL go to bin in_data-lo_p; otherwise consumed, not binned.
REQ-020 Bin increment SHALL saturate at 2^CW-1; back-to-back hits on the same bin SHALL each count (read-modify-write forwarding); update committed one cycle after acceptance.
REQ-021 Per-pixel running max SHALL update only when new count is strictly greater (earliest bin reaching the max wins ties).
REQ-022 After the last sample of a pass, pipeline SHALL drain (last update included), then: pass 0 with FINE_EN=1 -> WINDOW; else -> OUTPUT.
REQ-023 WINDOW SHALL compute all lo_p in one cycle, set pass=1, enter CLEAR.
REQ-024 OUTPUT SHALL present pixels 0..PIXELS-1 in order; out_valid held with stable data until out_ready; out_peak = lo_p + fine bin (fine) or bin << (NP-NB) (coarse only); out_count = max count.
REQ-025 Pixel with no binned samples SHALL report out_count=0, out_peak = lo_p (fine) or 0 (coarse).
REQ-026 After final output transfer SHALL set pass=0, clear lo_p, enter CLEAR.

Reset
REQ-027 res high at a clock edge SHALL force state CLEAR from bin 0, pass=0, lo_p=0, in_ready=0, out_valid=0, out_pixel=0, out_peak=0, out_count=0, busy=1, regardless of state or in-flight update.
REQ-028 In-flight accepted samples SHALL be discarded on reset; no partial result emitted.

Verification
REQ-029 Defaults, after reset: in_ready=0 for exactly 256 cycles, then 1.
REQ-030 Defaults, every sample 0x2A5 all pixels: coarse bin 10, lo=640; fine pass out_peak=0x2A5, out_count=32 each pixel, out_pixel 0,1,2,3.
REQ-031 Defaults, pixel 2 coarse samples 0xFC0, fine samples 0xFFE: lo=4032, fine bin 62, out_peak=0xFFE; 0xFFF samples never binned.
REQ-032 FINE_EN=0, ACQ=300, pixel 0 all 0x100: out_peak=0x100, out_count=255 (saturated), single pass only.
REQ-033 out_ready low 10 cycles during OUTPUT: out_valid/out_pixel/out_peak stable throughout; in_ready=0.
REQ-034 res asserted mid-ACCUM of fine pass: next cycle pass=0, in_ready=0, CLEAR restarts; following frame of 0x2A5 reproduces REQ-030.
